// File: rtl/fht_input_loader.sv
// fht_input_loader: accepts a stream of signed samples over a valid/ready
// handshake and writes them, in bit-reversed order, into the four RAM banks
// of the FHT buffer. Raises oFULL (with a one-cycle oDONE pulse) once a full
// frame of 4*2^A_BIT points is resident, then waits for iRELEASE.
//
// Ports:
//   iCLK, iRESET (async, active-low)
//   iSTART           begin a new frame (only honoured in IDLE, or with iRELEASE in FULL)
//   iDATA/iVALID     sample input; oREADY high while loading
//   iRELEASE         core is finished with the buffer (only honoured in FULL)
//   oFULL, oDONE     frame resident / one-cycle pulse when it becomes resident
//   oDATA_k, oADDR_WR_k, oWE_k   registered write port for bank k (k = 0..3)
module fht_input_loader #(
  parameter int unsigned D_BIT  = 17,
  parameter int unsigned A_BIT  = 8,
  parameter int unsigned IN_BIT = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic [IN_BIT-1:0] iDATA,
  input  logic              iVALID,
  output logic              oREADY,
  input  logic              iRELEASE,
  output logic              oFULL,
  output logic              oDONE,
  output logic [D_BIT-1:0]  oDATA_0,
  output logic [D_BIT-1:0]  oDATA_1,
  output logic [D_BIT-1:0]  oDATA_2,
  output logic [D_BIT-1:0]  oDATA_3,
  output logic [A_BIT-1:0]  oADDR_WR_0,
  output logic [A_BIT-1:0]  oADDR_WR_1,
  output logic [A_BIT-1:0]  oADDR_WR_2,
  output logic [A_BIT-1:0]  oADDR_WR_3,
  output logic              oWE_0,
  output logic              oWE_1,
  output logic              oWE_2,
  output logic              oWE_3
);

  localparam int unsigned CntW = A_BIT + 2;

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   n_q, n_d, n_rev;
  logic              ready_q, full_q, done_q, done_d;
  logic [3:0]        we_q, we_d;
  logic [A_BIT-1:0]  addr_q, addr_d;
  logic [D_BIT-1:0]  data_q, data_d;
  logic              xfer;

  // ready_q mirrors "state is LOAD", so it doubles as the accept qualifier.
  assign xfer = iVALID & ready_q;

  always_comb begin
    for (int i = 0; i < int'(CntW); i++) begin
      n_rev[i] = n_q[CntW-1-i];
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    we_d    = '0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (iSTART) begin
          state_d = StLoad;
          n_d     = '0;
        end
      end
      StLoad: begin
        if (xfer) begin
          // Top two reversed bits pick the bank, the rest the word address.
          we_d[n_rev[CntW-1 -: 2]] = 1'b1;
          addr_d = n_rev[A_BIT-1:0];
          data_d = D_BIT'($signed(iDATA));
          n_d    = n_q + CntW'(1);  // wraps to 0 on the final sample
          if (n_q == '1) begin
            state_d = StFull;
            done_d  = 1'b1;
          end
        end
      end
      StFull: begin
        if (iRELEASE) begin
          state_d = iSTART ? StLoad : StIdle;
          n_d     = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= StIdle;
      n_q     <= '0;
      ready_q <= 1'b0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      ready_q <= (state_d == StLoad);
      full_q  <= (state_d == StFull);
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign oREADY     = ready_q;
  assign oFULL      = full_q;
  assign oDONE      = done_q;
  assign oDATA_0    = data_q;
  assign oDATA_1    = data_q;
  assign oDATA_2    = data_q;
  assign oDATA_3    = data_q;
  assign oADDR_WR_0 = addr_q;
  assign oADDR_WR_1 = addr_q;
  assign oADDR_WR_2 = addr_q;
  assign oADDR_WR_3 = addr_q;
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];

endmodule
